bus_arbiter: RTL and testbench

- Two-master arbiter and sequencer for the single external data bus (address, write data, read data, write enable, chip select).
- Master 0 is the CPU memory stage. Master 1 is a DMA/peripheral engine.
- Grants one transaction at a time using round-robin priority.
- Drives the bus for a fixed number of wait cycles, captures read data, and returns a one-cycle ack to the winning master.

---
 rtl/bus_arbiter.sv | 141 ++++++++++++++
 tb/tb_bus_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter/sequencer for the shared external data bus.
// States: IDLE = waiting for a request | BUSY = driving bus_cs for WAIT_CYCLES | DONE = ack to winner.
module bus_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  output logic          bus_we,
  output logic          bus_cs,
  input  logic [DW-1:0] bus_rdata,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          owner_q, owner_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          cs_q, cs_d;
  logic          m0_ack_q, m0_ack_d;
  logic          m1_ack_q, m1_ack_d;
  logic [DW-1:0] m0_rdata_q, m0_rdata_d;
  logic [DW-1:0] m1_rdata_q, m1_rdata_d;
  logic          win;

  // On a tie the master that did not win last time goes next.
  assign win = (m0_req && m1_req) ? ~owner_q : m1_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      owner_q    <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      cs_q       <= 1'b0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      cs_q       <= cs_d;
      m0_ack_q   <= m0_ack_d;
      m1_ack_q   <= m1_ack_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    cs_d       = cs_q;
    m0_ack_d   = 1'b0;
    m1_ack_d   = 1'b0;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          owner_d = win;
          addr_d  = win ? m1_addr  : m0_addr;
          wdata_d = win ? m1_wdata : m0_wdata;
          we_d    = win ? m1_we    : m0_we;
          cs_d    = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Read data is captured even for writes; masters ignore it then.
          if (owner_q) m1_rdata_d = bus_rdata;
          else         m0_rdata_d = bus_rdata;
          cs_d     = 1'b0;
          we_d     = 1'b0;
          m0_ack_d = ~owner_q;
          m1_ack_d = owner_q;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign m0_ack    = m0_ack_q;
  assign m1_ack    = m1_ack_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_we    = we_q;
  assign bus_cs    = cs_q;
  assign busy      = (state_q != IDLE);
  assign owner     = owner_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: the stimulus pushes expected transactions in grant order,
// a negedge monitor pops them as the bus and acks appear.
`timescale 1ns/1ps
module tb_bus_arbiter;
  localparam int W = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m0_ack, m1_req, m1_we, m1_ack;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_we, bus_cs, busy, owner;

  always #5 clk = ~clk;

  bus_arbiter #(.WAIT_CYCLES(W), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_cs(bus_cs),
    .bus_rdata(bus_rdata), .busy(busy), .owner(owner)
  );

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'hDEAD_BEEF;
    return {~a[15:0], a[15:0]} ^ 32'h0F0F_0000;
  endfunction

  assign bus_rdata = mem_model(bus_addr);

  typedef struct {
    bit          m;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual 0x%08h required 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: actual %s (t=%0t)", name, what, $time);
  endtask

  task automatic push_exp(input bit m, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    e.m = m; e.we = we; e.addr = addr; e.wdata = wdata; e.rdata = mem_model(addr);
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit m, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit keep);
    int t;
    if (!m) begin m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_req = 1'b1; end
    else    begin m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_req = 1'b1; end
    t = 0;
    do begin
      @(posedge clk); #1; t++;
    end while (!(m ? m1_ack : m0_ack) && t < 100);
    if (!(m ? m1_ack : m0_ack))
      fail_now(m ? "m1_ack_timeout" : "m0_ack_timeout", "no ack in 100 cycles, required an ack");
    if (!keep) begin
      if (!m) m0_req = 1'b0; else m1_req = 1'b0;
    end
  endtask

  task automatic drive_seq(input bit m);
    for (int i = 0; i < 4; i++) begin
      if (!m) drive(1'b0, i[0], 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), i < 3);
      else    drive(1'b1, ~i[0], 32'h200 + 32'(4 * i), 32'hB000_0000 + 32'(i), i < 3);
    end
  endtask

  // Monitor / scoreboard
  int          cyc = 0, grant_cyc = 0, last_ack = -1, cs_len = 0;
  bit          in_tx = 0, cur_ok = 0, prev_ack = 0, chk_spacing = 0;
  exp_t        cur;
  logic [31:0] last_rd [2];

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      in_tx = 0; cur_ok = 0; cs_len = 0; prev_ack = 0;
      last_rd[0] = '0; last_rd[1] = '0;
    end else begin
      if (bus_cs) begin
        if (!in_tx) begin
          in_tx = 1; cs_len = 0; grant_cyc = cyc;
          cur_ok = (exp_q.size() != 0);
          if (cur_ok) cur = exp_q.pop_front();
          else fail_now("unexpected_cs", "bus_cs asserted, required no transaction");
        end
        cs_len++;
        if (cur_ok) begin
          check("bus_addr", bus_addr, cur.addr);
          check("bus_wdata", bus_wdata, cur.wdata);
          check("bus_we", 32'(bus_we), 32'(cur.we));
        end
        check("busy_during_cs", 32'(busy), 32'd1);
      end
      if (m0_ack || m1_ack) begin
        if (prev_ack) fail_now("ack_single_cycle", "ack high two cycles, required one");
        if (!in_tx || !cur_ok) begin
          fail_now("unexpected_ack", "ack pulse, required none");
        end else begin
          check("ack_master", 32'(m1_ack), 32'(cur.m));
          check("ack_both", 32'(m0_ack & m1_ack), 32'd0);
          check("cs_cycles", 32'(cs_len), 32'(W));
          check("cs_in_done", 32'(bus_cs), 32'd0);
          check("we_in_done", 32'(bus_we), 32'd0);
          check("ack_latency", 32'(cyc - grant_cyc), 32'(W));
          check("rdata", cur.m ? m1_rdata : m0_rdata, cur.rdata);
          check("other_rdata_held", cur.m ? m0_rdata : m1_rdata, last_rd[!cur.m]);
          last_rd[cur.m] = cur.rdata;
          check("owner", 32'(owner), 32'(cur.m));
          if (chk_spacing && last_ack >= 0) check("ack_spacing", 32'(cyc - last_ack), 32'(W + 2));
          last_ack = cyc;
        end
        in_tx = 0; cur_ok = 0;
      end
      prev_ack = m0_ack | m1_ack;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    rst = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Reset and idle
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_cs", 32'(bus_cs), 32'd0);
      check("idle_we", 32'(bus_we), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_owner", 32'(owner), 32'd1);
      check("idle_acks", 32'({m0_ack, m1_ack}), 32'd0);
      check("idle_addr", bus_addr, 32'd0);
      check("idle_wdata", bus_wdata, 32'd0);
      check("idle_rdata", m0_rdata | m1_rdata, 32'd0);
    end
    @(posedge clk); #1;

    // Single read by m0, single write by m1
    push_exp(1'b0, 1'b0, 32'h0000_0010, 32'h0);
    drive(1'b0, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
    push_exp(1'b1, 1'b1, 32'h0000_0040, 32'hCAFE_F00D);
    drive(1'b1, 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 1'b0);

    // Simultaneous continuous requests: owner is m1, so m0 goes first
    for (int i = 0; i < 4; i++) begin
      push_exp(1'b0, i[0], 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i));
      push_exp(1'b1, ~i[0], 32'h200 + 32'(4 * i), 32'hB000_0000 + 32'(i));
    end
    chk_spacing = 1; last_ack = -1;
    fork
      drive_seq(1'b0);
      drive_seq(1'b1);
    join
    chk_spacing = 0;
    repeat (2) @(posedge clk); #1;

    // Master changes its inputs while BUSY
    push_exp(1'b0, 1'b1, 32'h0000_0010, 32'h5555_AAAA);
    m0_we = 1'b1; m0_addr = 32'h10; m0_wdata = 32'h5555_AAAA; m0_req = 1'b1;
    t = 0;
    do begin @(posedge clk); #1; t++; end while (!bus_cs && t < 50);
    if (!bus_cs) fail_now("cs_timeout", "no bus_cs, required grant");
    m0_addr = 32'h20; m0_wdata = 32'h1234_5678; m0_we = 1'b0;
    t = 0;
    do begin @(posedge clk); #1; t++; end while (!m0_ack && t < 50);
    if (!m0_ack) fail_now("m0_ack_timeout", "no ack, required ack");
    m0_req = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Reset during BUSY of an m0 write: owner was m0, must return to 1
    push_exp(1'b0, 1'b1, 32'h0000_0080, 32'hA5A5_A5A5);
    m0_we = 1'b1; m0_addr = 32'h80; m0_wdata = 32'hA5A5_A5A5; m0_req = 1'b1;
    t = 0;
    do begin @(posedge clk); #1; t++; end while (!bus_cs && t < 50);
    if (!bus_cs) fail_now("cs_timeout", "no bus_cs, required grant");
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("rst_cs_drop", 32'(bus_cs), 32'd0);
    check("rst_we_drop", 32'(bus_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_owner", 32'(owner), 32'd1);
    check("rst_ack", 32'({m0_ack, m1_ack}), 32'd0);
    m0_req = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_no_ack", 32'({m0_ack, m1_ack}), 32'd0);
      check("post_rst_no_cs", 32'(bus_cs), 32'd0);
    end
    @(posedge clk); #1;

    // First tie after reset goes to m0
    push_exp(1'b0, 1'b0, 32'h0000_0300, 32'h0);
    push_exp(1'b1, 1'b0, 32'h0000_0304, 32'h0);
    fork
      drive(1'b0, 1'b0, 32'h0000_0300, 32'h0, 1'b0);
      drive(1'b1, 1'b0, 32'h0000_0304, 32'h0, 1'b0);
    join
    repeat (4) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
